lmac_txfifo_rd: RTL



---
 rtl/lmac_txfifo_rd.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lmac_txfifo_rd.sv
// lmac_txfifo_rd: read side of the LMAC TX packet-data FIFO.
// Paces buffer reads to the line rate, feeds a 2-entry output queue
// and hands 64-bit words to the MAC over a valid/ready handshake.
// Ports: clk/RESETN; MODE_* rate select; TXFIFO_WR_STROBE in;
// TXFIFO_BUFF_raddr/ren/rdata buffer port; TXFIFO_BUFF_RD_PTR,
// TXFIFO_RD_POP, TXFIFO_RUSED_QWD status; TXFIFO_RD_OUTPUT/EN/READY
// MAC handshake; TXFIFO_RD_EMPTY.
// Option LMAC_TXFIFO_RD_STATS_EN adds TXFIFO_RD_WORDS, TXFIFO_RD_OVF.
module lmac_txfifo_rd #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 5,
  parameter int DW    = 64,
  parameter int CNT_W = 13
) (
  input  logic                       clk,
  input  logic                       RESETN,
  input  logic                       MODE_10G,
  input  logic                       MODE_5G,
  input  logic                       MODE_2P5G,
  input  logic                       MODE_1G,
  input  logic                       TXFIFO_WR_STROBE,
  output logic [$clog2(DEPTH)-1:0]   TXFIFO_BUFF_raddr,
  output logic                       TXFIFO_BUFF_ren,
  input  logic [DW-1:0]              TXFIFO_BUFF_rdata,
  output logic [PTR_W-1:0]           TXFIFO_BUFF_RD_PTR,
  output logic                       TXFIFO_RD_POP,
  output logic [CNT_W-1:0]           TXFIFO_RUSED_QWD,
  output logic [DW-1:0]              TXFIFO_RD_OUTPUT,
  output logic                       TXFIFO_RD_EN,
  input  logic                       TXFIFO_RD_READY,
`ifdef LMAC_TXFIFO_RD_STATS_EN
  output logic [31:0]                TXFIFO_RD_WORDS,
  output logic                       TXFIFO_RD_OVF,
`endif
  output logic                       TXFIFO_RD_EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    M_NONE, M_10G, M_5G, M_2P5G, M_1G
  } mode_e;

  mode_e          mode;
  mode_e          mode_q;
  logic [3:0]     last;
  logic [3:0]     pace_q;
  logic [3:0]     pace_cur;
  logic [3:0]     pace_d;
  logic           tick;

  logic [UW-1:0]  u_q;
  logic [UW-1:0]  u_d;
  logic [AW-1:0]  ptr_q;
  logic           fly_q;
  logic [1:0]     qcnt_q;
  logic [1:0]     qcnt_d;
  logic [DW-1:0]  q0_q;
  logic [DW-1:0]  q1_q;
  logic [DW-1:0]  q0_d;
  logic [DW-1:0]  q1_d;
  logic [2:0]     occ;
  logic           pop_out;
  logic           ren;
  logic           wr_ok;
  logic           full;
  logic           empty_q;

  always_comb begin
    mode = M_NONE;
    last = 4'd0;
    priority case (1'b1)
      MODE_10G:  begin mode = M_10G;  last = 4'd0; end
      MODE_5G:   begin mode = M_5G;   last = 4'd1; end
      MODE_2P5G: begin mode = M_2P5G; last = 4'd3; end
      MODE_1G:   begin mode = M_1G;   last = 4'd9; end
      default:   begin mode = M_NONE; last = 4'd0; end
    endcase
  end

  // A mode change restarts the pace count in the same cycle.
  assign pace_cur = (mode != mode_q) ? 4'd0 : pace_q;
  assign tick     = (mode != M_NONE) && (pace_cur == 4'd0);
  assign pace_d   = (mode == M_NONE || pace_cur == last) ?
                    4'd0 : pace_cur + 4'd1;

  assign full    = (u_q == UW'(DEPTH));
  assign pop_out = (qcnt_q != 2'd0) && TXFIFO_RD_READY;
  // Queue slots that will be taken once in-flight data lands.
  assign occ     = {1'b0, qcnt_q} + {2'b0, fly_q} - {2'b0, pop_out};
  assign ren     = (u_q != '0) && tick && (occ < 3'd2);
  assign wr_ok   = TXFIFO_WR_STROBE && (!full || ren);
  assign u_d     = u_q + UW'(wr_ok) - UW'(ren);

  // q1 is kept zero below two entries, q0 zero when empty,
  // so the head word returns to 0 once the queue drains.
  always_comb begin
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    if (fly_q && pop_out) begin
      if (qcnt_q == 2'd2) begin
        q0_d = q1_q;
        q1_d = TXFIFO_BUFF_rdata;
      end else begin
        q0_d = TXFIFO_BUFF_rdata;
      end
    end else if (fly_q) begin
      if (qcnt_q == 2'd0) q0_d = TXFIFO_BUFF_rdata;
      else                q1_d = TXFIFO_BUFF_rdata;
      qcnt_d = qcnt_q + 2'd1;
    end else if (pop_out) begin
      q0_d   = q1_q;
      q1_d   = '0;
      qcnt_d = qcnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      mode_q  <= M_NONE;
      pace_q  <= 4'd0;
      u_q     <= '0;
      ptr_q   <= '0;
      fly_q   <= 1'b0;
      qcnt_q  <= 2'd0;
      q0_q    <= '0;
      q1_q    <= '0;
      empty_q <= 1'b1;
    end else begin
      mode_q  <= mode;
      pace_q  <= pace_d;
      u_q     <= u_d;
      if (ren) ptr_q <= ptr_q + 1'b1;
      fly_q   <= ren;
      qcnt_q  <= qcnt_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      empty_q <= (u_d == '0) && !ren && (qcnt_d == 2'd0);
    end
  end

`ifdef LMAC_TXFIFO_RD_STATS_EN
  logic [31:0] words_q;
  logic        ovf_q;

  always_ff @(posedge clk or negedge RESETN) begin
    if (!RESETN) begin
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop_out && words_q != 32'hFFFF_FFFF)
        words_q <= words_q + 32'd1;
      if (TXFIFO_WR_STROBE && full && !ren)
        ovf_q <= 1'b1;
    end
  end

  assign TXFIFO_RD_WORDS = words_q;
  assign TXFIFO_RD_OVF   = ovf_q;
`endif

  assign TXFIFO_BUFF_raddr  = ptr_q;
  assign TXFIFO_BUFF_ren    = ren;
  assign TXFIFO_RD_POP      = ren;
  assign TXFIFO_BUFF_RD_PTR = PTR_W'(ptr_q);
  assign TXFIFO_RUSED_QWD   = CNT_W'(u_q);
  assign TXFIFO_RD_OUTPUT   = q0_q;
  assign TXFIFO_RD_EN       = (qcnt_q != 2'd0);
  assign TXFIFO_RD_EMPTY    = empty_q;

endmodule
